// File: rtl/spi_frame_unpacker.sv
// Buffers completed SPI receive frames in a small FIFO and streams each one
// out MSB byte first on a valid/ready byte interface.
module spi_frame_unpacker #(
  parameter int FRAME_BITS = 120,
  parameter int DEPTH      = 4
) (
  input  logic                    m_clk,
  input  logic                    n_reset,
  input  logic [FRAME_BITS-1:0]   frame_in,
  input  logic                    frame_valid,
  output logic [7:0]              byte_out,
  output logic                    byte_valid,
  output logic                    byte_last,
  input  logic                    byte_ready,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  input  logic                    ovf_clr
);
  localparam int NBYTES = FRAME_BITS / 8;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                          state, state_n;
  logic [DEPTH-1:0][FRAME_BITS-1:0] mem;
  logic [PW-1:0]                   wr_ptr, rd_ptr;
  logic [FRAME_BITS-1:0]           sr;
  logic [IW-1:0]                   idx;
  logic                            wr_en, drop, pop, advance, at_last, fifo_full;

  // Fullness is judged before any same-cycle pop, so a full FIFO always drops.
  assign fifo_full = (fifo_count == CW'(DEPTH));
  assign wr_en     = frame_valid && !fifo_full;
  assign drop      = frame_valid && fifo_full;
  assign at_last   = (idx == IW'(NBYTES - 1));

  always_ff @(posedge m_clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE: if (fifo_count != '0) begin
        pop     = 1'b1;
        state_n = SEND;
      end
      SEND: if (byte_ready) begin
        if (!at_last)                advance = 1'b1;
        else if (fifo_count != '0)   pop     = 1'b1;
        else                         state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Storage is not reset; occupancy is tracked solely by the pointers/count.
  always_ff @(posedge m_clk) begin
    if (wr_en) mem[wr_ptr] <= frame_in;
  end

  always_ff @(posedge m_clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge m_clk or negedge n_reset) begin
    if (!n_reset) begin
      sr  <= '0;
      idx <= '0;
    end else if (pop) begin
      sr  <= mem[rd_ptr];
      idx <= '0;
    end else if (advance) begin
      sr  <= sr << 8;
      idx <= idx + IW'(1);
    end else if (state == SEND && state_n == IDLE) begin
      sr  <= '0;
      idx <= '0;
    end
  end

  assign byte_valid = (state == SEND);
  assign byte_out   = byte_valid ? sr[FRAME_BITS-1 -: 8] : 8'h00;
  assign byte_last  = byte_valid && at_last;

endmodule
